uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter FPGA_clk_freq, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter baudrate, default 115200, serial bit rate; CLKS_PER_BIT = FPGA_clk_freq / baudrate (integer divide; 434 at defaults).
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_RX_Serial  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port o_RX_DV  output  1  one-cycle pulse, o_RX_Byte newly valid.
REQ-007 SHALL have port o_RX_Byte  output  8  last correctly framed byte received.
REQ-008 SHALL have port o_RX_Active  output  1  high while a frame is being received.
REQ-009 SHALL have port o_RX_Frame_Err  output  1  one-cycle pulse, stop bit sampled low.

Function
REQ-010 SHALL pass i_RX_Serial through a 2-flop synchronizer (both flops reset to 1); all decisions use the second flop output "rxs".
REQ-011 SHALL implement states IDLE, START_BIT, DATA_BITS, STOP_BIT, CLEANUP; any other encoding SHALL go to IDLE next cycle.
REQ-012 IDLE: clock counter and bit index held at 0; rxs==0 -> START_BIT, o_RX_Active=1 from next cycle.
REQ-013 START_BIT: counter increments each cycle; at counter == (CLKS_PER_BIT-1)/2 rxs is sampled: 0 -> DATA_BITS with counter=0; 1 -> IDLE (glitch rejected, no outputs pulsed, o_RX_Active=0).
REQ-014 DATA_BITS: counter counts 0..CLKS_PER_BIT-1; at CLKS_PER_BIT-1 rxs is stored into shift data bit [index], counter=0; bits LSB first; after index 7 -> STOP_BIT, index=0.
REQ-015 STOP_BIT: at counter == CLKS_PER_BIT-1, rxs sampled: 1 -> o_RX_Byte loaded from shift data and o_RX_DV=1 for exactly one cycle; 0 -> o_RX_Frame_Err=1 for exactly one cycle, o_RX_Byte unchanged, o_RX_DV stays 0; either case -> CLEANUP, o_RX_Active=0.
REQ-016 CLEANUP: stays while rxs==0 (break/held-low line never re-triggers); rxs==1 -> IDLE.
REQ-017 o_RX_DV and o_RX_Frame_Err SHALL never be high in the same cycle and SHALL each be high at most one cycle per frame.
REQ-018 o_RX_Byte SHALL hold its value between o_RX_DV pulses.
REQ-019 Counter width SHALL be $clog2(CLKS_PER_BIT)+1 bits; no wrap within a bit period.
REQ-020 Latency: o_RX_DV SHALL assert 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 2 cycles (+/-1) after the start-bit falling edge at i_RX_Serial.
REQ-021 A new start bit whose falling edge arrives during CLEANUP or the cycle after SHALL be received correctly (back-to-back frames, one stop bit).
REQ-022 i_RX_Serial changes during mid-bit counting SHALL have no effect except at the sample points defined above.

Reset
REQ-023 On rst: state=IDLE, counter=0, index=0, shift data=0x00, synchronizer flops=1.
REQ-024 On rst: o_RX_DV=0, o_RX_Byte=0x00, o_RX_Active=0, o_RX_Frame_Err=0.
REQ-025 rst asserted mid-frame SHALL abort the frame with no DV/error pulse; reception resumes on the next falling edge after rst deasserts.

Verification
REQ-026 Drive 0xA5, 8N1 at 434 clk/bit -> one o_RX_DV pulse, o_RX_Byte=0xA5, o_RX_Frame_Err never high, o_RX_Active high for the frame.
REQ-027 Back-to-back 0x00 then 0xFF with no idle gap -> two DV pulses, bytes 0x00 then 0xFF, latency per REQ-020.
REQ-028 Low glitch of 100 clk on idle line -> no DV, no error, state returns to IDLE, o_RX_Active back to 0.
REQ-029 After good 0x3C, send 0x55 with stop bit 0 -> o_RX_Frame_Err single pulse, no DV, o_RX_Byte stays 0x3C; line held low 20 bit times then 0x81 -> only 0x81 received.
REQ-030 Assert rst during bit 4 of 0xC3 -> all outputs 0 next cycle, no pulses; subsequent 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver.
//
// The serial line is brought into the clk domain through a two-flop
// synchronizer (both flops reset high, matching the idle line), then a
// five-state FSM finds the start bit, centres on it and samples each
// following bit in its middle. Only correctly framed bytes reach o_RX_Byte.
//
// Handshake: o_RX_DV is a valid-only strobe with no ready. It is high for
// exactly one clk cycle per good frame, and o_RX_Byte is valid in that cycle.
// o_RX_Byte then holds its value until the next o_RX_DV. A consumer that
// wants the byte must capture it on the strobe, because there is no
// back-pressure.
//
// Parameters
//   FPGA_clk_freq  system clock frequency in Hz
//   baudrate       serial bit rate; CLKS_PER_BIT = FPGA_clk_freq / baudrate
//
// Ports
//   clk             clock, rising edge
//   rst             synchronous, active-high reset
//   i_RX_Serial     asynchronous serial input, idle high
//   o_RX_DV         one-cycle pulse: o_RX_Byte newly valid
//   o_RX_Byte       last correctly framed byte
//   o_RX_Active     high while a frame is being received
//   o_RX_Frame_Err  one-cycle pulse: stop bit was sampled low
//   dbg_state       current FSM state encoding (debug visibility)
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int FPGA_clk_freq = 50000000,
    parameter int baudrate      = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Active,
    output logic       o_RX_Frame_Err,
    output logic [2:0] dbg_state
);

    localparam int CLKS_PER_BIT = FPGA_clk_freq / baudrate;
    localparam int HALF_BIT     = (CLKS_PER_BIT - 1) / 2;
    // One spare bit so the counter never wraps within a bit period.
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA_BITS = 3'd2,
        STOP_BIT  = 3'd3,
        CLEANUP   = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_data;
    logic             rx_meta;
    logic             rxs;

    assign dbg_state = state;

    // Two-flop synchronizer. It resets to 1 so that reset does not look like
    // a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= i_RX_Serial;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            clk_cnt        <= '0;
            bit_idx        <= '0;
            shift_data     <= 8'h00;
            o_RX_DV        <= 1'b0;
            o_RX_Byte      <= 8'h00;
            o_RX_Active    <= 1'b0;
            o_RX_Frame_Err <= 1'b0;
        end else begin
            // Both strobes default low, so each one lasts a single cycle.
            o_RX_DV        <= 1'b0;
            o_RX_Frame_Err <= 1'b0;

            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (!rxs) begin
                        state       <= START_BIT;
                        o_RX_Active <= 1'b1;
                    end
                end

                // Re-check the line at the middle of the start bit. A high
                // level there means the low was a glitch, so the frame is
                // dropped silently.
                START_BIT: begin
                    if (clk_cnt == CNT_HALF) begin
                        clk_cnt <= '0;
                        if (!rxs) begin
                            state <= DATA_BITS;
                        end else begin
                            state       <= IDLE;
                            o_RX_Active <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                // The count started at the start-bit centre, so each full
                // bit period lands on the centre of the next data bit.
                DATA_BITS: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt             <= '0;
                        shift_data[bit_idx] <= rxs;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= STOP_BIT;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                STOP_BIT: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt     <= '0;
                        state       <= CLEANUP;
                        o_RX_Active <= 1'b0;
                        if (rxs) begin
                            o_RX_Byte <= shift_data;
                            o_RX_DV   <= 1'b1;
                        end else begin
                            o_RX_Frame_Err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                // Wait for the line to return high. A held-low (break) line
                // then cannot be taken for a new start bit.
                CLEANUP: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (rxs) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state       <= IDLE;
                    clk_cnt     <= '0;
                    bit_idx     <= '0;
                    o_RX_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx at the default 434 clk/bit.
//
// The driver pushes each frame's expected outcome, {is_err, byte}, into
// exp_q. It also pushes the cycle of the start-bit falling edge into
// start_q. A monitor on the falling clock edge pops one entry whenever
// o_RX_DV or o_RX_Frame_Err fires, then checks the outcome kind, the byte
// and the latency. Directed checks of o_RX_Active, the state and the reset
// values run inline in the driver.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB     = 434;
    localparam int LAT_NOM = 2 + (CPB - 1) / 2 + 9 * CPB + 2;  // 4126

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       o_RX_Active;
    logic       o_RX_Frame_Err;
    logic [2:0] dbg_state;

    uart_rx dut (
        .clk            (clk),
        .rst            (rst),
        .i_RX_Serial    (rx),
        .o_RX_DV        (o_RX_DV),
        .o_RX_Byte      (o_RX_Byte),
        .o_RX_Active    (o_RX_Active),
        .o_RX_Frame_Err (o_RX_Frame_Err),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [8:0] exp_q[$];
    int         start_q[$];
    int         pass_cnt  = 0;
    int         total_cnt = 0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total_cnt++;
        if (act >= lo && act <= hi) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    endtask

    // ---------------- monitor ----------------
    logic [8:0] mon_e;
    int         mon_s;
    always @(negedge clk) begin
        if (o_RX_DV || o_RX_Frame_Err) begin
            check("dv_ferr_exclusive", {31'd0, o_RX_DV & o_RX_Frame_Err}, 32'd0);
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_output: got dv=%0b ferr=%0b byte=0x%0h, expected none",
                         o_RX_DV, o_RX_Frame_Err, o_RX_Byte);
            end else begin
                mon_e = exp_q.pop_front();
                mon_s = start_q.pop_front();
                check("output_kind_ferr", {31'd0, o_RX_Frame_Err}, {31'd0, mon_e[8]});
                check("rx_byte", {24'd0, o_RX_Byte}, {24'd0, mon_e[7:0]});
                check_range("latency", cyc - mon_s, LAT_NOM - 1, LAT_NOM + 1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        wait_clks(CPB);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dv"},     {31'd0, o_RX_DV},        32'd0);
        check({tag, "_byte"},   {24'd0, o_RX_Byte},      32'd0);
        check({tag, "_active"}, {31'd0, o_RX_Active},    32'd0);
        check({tag, "_ferr"},   {31'd0, o_RX_Frame_Err}, 32'd0);
        check({tag, "_state"},  {29'd0, dbg_state},      32'd0);
    endtask

    // A full 8N1 frame. With stop = 0 the line is left low on return.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        if (stop) begin
            exp_q.push_back({1'b0, b});
            last_good = b;
        end else begin
            exp_q.push_back({1'b1, last_good});
        end
        start_q.push_back(cyc);
        drive_bit(1'b0);
        check("active_in_frame", {31'd0, o_RX_Active}, 32'd1);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        check("active_after_frame", {31'd0, o_RX_Active}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] c3 = 8'hC3;
    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        wait_clks(5);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_clks(10);

        // Single good byte.
        send_frame(8'hA5, 1'b1);
        wait_clks(2 * CPB);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_clks(2 * CPB);

        // 100-cycle low glitch on the idle line.
        rx = 1'b0;
        wait_clks(50);
        check("glitch_active_during", {31'd0, o_RX_Active}, 32'd1);
        wait_clks(50);
        rx = 1'b1;
        wait_clks(300);
        check("glitch_active_after", {31'd0, o_RX_Active}, 32'd0);
        check("glitch_state_idle", {29'd0, dbg_state}, 32'd0);

        // Good byte, then a framing error, then a held-low break.
        send_frame(8'h3C, 1'b1);
        wait_clks(2 * CPB);
        send_frame(8'h55, 1'b0);
        wait_clks(20 * CPB);
        check("break_byte_held", {24'd0, o_RX_Byte}, 32'h3C);
        check("break_state_cleanup", {29'd0, dbg_state}, 32'd4);
        check("break_active", {31'd0, o_RX_Active}, 32'd0);
        rx = 1'b1;
        wait_clks(2 * CPB);
        send_frame(8'h81, 1'b1);
        wait_clks(2 * CPB);

        // Reset during bit 4 of 0xC3. No outcome is queued for this frame.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(c3[i]);
        rx = c3[4];
        wait_clks(200);
        check("mid_frame_active", {31'd0, o_RX_Active}, 32'd1);
        rst = 1'b1;
        wait_clks(1);
        check_reset_outputs("midreset");
        last_good = 8'h00;
        rx = 1'b1;
        wait_clks(5);
        rst = 1'b0;
        wait_clks(2 * CPB);
        send_frame(8'h5A, 1'b1);
        wait_clks(2 * CPB);

        // Drain any outstanding expectations, with a bounded wait.
        for (int i = 0; i < 10000 && exp_q.size() != 0; i++) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
